// File: rtl/drm_freq_probe_master.sv
// drm_freq_probe_master: AXI4-Lite master that checks the frequency-counter
// version word, clears the controller-side counter, waits a window of
// external timebase ticks and reads the counter back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// RD_VER_A | version read address phase (araddr = BASE_ADDR)
// RD_VER_R | version read data phase, compare against EXP_VERSION
// WR_CLR   | counter clear write, AW and W handshakes tracked separately
// WR_B     | write response phase
// WAIT_WIN | counting window_tick pulses up to WINDOW_TICKS
// RD_CNT_A | counter read address phase (araddr = BASE_ADDR + 4)
// RD_CNT_R | counter read data phase, latch result and status
// DONE     | one-cycle done pulse, then back to IDLE
module drm_freq_probe_master #(
    parameter logic [15:0] BASE_ADDR    = 16'hFFF8,
    parameter logic [31:0] EXP_VERSION  = 32'h60DC0DE0,
    parameter int          WINDOW_TICKS = 1000,
    parameter int          TIMEOUT      = 1024
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_arstn,
    input  logic        start,
    input  logic        window_tick,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [2:0]  err,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [15:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [15:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    localparam logic [15:0] CNT_ADDR = BASE_ADDR + 16'd4;
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] PH_LAST  = TW'(TIMEOUT - 1);
    localparam logic [15:0]   TICK_LAST = 16'(WINDOW_TICKS - 1);

    localparam logic [2:0] E_OK  = 3'd0;
    localparam logic [2:0] E_VER = 3'd1;
    localparam logic [2:0] E_TMO = 3'd2;
    localparam logic [2:0] E_RSP = 3'd3;
    localparam logic [2:0] E_SAT = 3'd4;

    typedef enum logic [3:0] {
        IDLE, RD_VER_A, RD_VER_R, WR_CLR, WR_B, WAIT_WIN, RD_CNT_A, RD_CNT_R, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] ph_q, ph_d;
    logic [15:0]   tick_q, tick_d;
    logic          win_entry_q, win_entry_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic [15:0]   araddr_q, araddr_d;
    logic [15:0]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   result_q, result_d;
    logic [2:0]    err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_now, w_now, axi_st, tmo;

    assign ar_hs = arvalid_q & m_axi_arready;
    assign r_hs  = rready_q & m_axi_rvalid;
    assign aw_hs = awvalid_q & m_axi_awready;
    assign w_hs  = wvalid_q & m_axi_wready;
    assign b_hs  = bready_q & m_axi_bvalid;
    assign tmo   = (ph_q == PH_LAST);

    // Next-state and next-output logic; every bus output is registered from here.
    always_comb begin
        state_d     = state_q;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        result_d    = result_q;
        err_d       = err_q;
        tick_d      = tick_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_now      = aw_done_q | aw_hs;
        w_now       = w_done_q | w_hs;
        axi_st      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d  = '0;
                    err_d     = E_OK;
                    state_d   = RD_VER_A;
                    arvalid_d = 1'b1;
                    araddr_d  = BASE_ADDR;
                end
            end
            RD_VER_A, RD_CNT_A: begin
                axi_st = 1'b1;
                if (ar_hs) begin
                    state_d  = (state_q == RD_VER_A) ? RD_VER_R : RD_CNT_R;
                    rready_d = 1'b1;
                end else if (tmo) begin
                    err_d   = E_TMO;
                    state_d = DONE;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            RD_VER_R: begin
                axi_st = 1'b1;
                if (r_hs) begin
                    if (m_axi_rresp != 2'b00) begin
                        err_d   = E_RSP;
                        state_d = DONE;
                    end else if (m_axi_rdata != EXP_VERSION) begin
                        err_d   = E_VER;
                        state_d = DONE;
                    end else begin
                        state_d   = WR_CLR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = CNT_ADDR;
                        wdata_d   = '0;
                        wstrb_d   = 4'hF;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end else if (tmo) begin
                    err_d   = E_TMO;
                    state_d = DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            WR_CLR: begin
                // AW and W complete independently; a slave may hold wready until after awready.
                axi_st = 1'b1;
                if (aw_now && w_now) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end else if (tmo) begin
                    err_d   = E_TMO;
                    state_d = DONE;
                end else begin
                    awvalid_d = ~aw_now;
                    wvalid_d  = ~w_now;
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            WR_B: begin
                axi_st = 1'b1;
                if (b_hs) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_d   = E_RSP;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_WIN;
                        tick_d  = '0;
                    end
                end else if (tmo) begin
                    err_d   = E_TMO;
                    state_d = DONE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            WAIT_WIN: begin
                // A tick coinciding with the first window cycle is deliberately not counted.
                if (window_tick && !win_entry_q) begin
                    if (tick_q == TICK_LAST) begin
                        state_d   = RD_CNT_A;
                        arvalid_d = 1'b1;
                        araddr_d  = CNT_ADDR;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
            end
            RD_CNT_R: begin
                axi_st = 1'b1;
                if (r_hs) begin
                    result_d = m_axi_rdata;
                    state_d  = DONE;
                    if (m_axi_rresp != 2'b00)
                        err_d = E_RSP;
                    else if (m_axi_rdata == 32'hFFFF_FFFF)
                        err_d = E_SAT;
                    else
                        err_d = E_OK;
                end else if (tmo) begin
                    err_d   = E_TMO;
                    state_d = DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ph_d        = (axi_st && (state_d == state_q)) ? ph_q + TW'(1) : '0;
        win_entry_d = (state_d == WAIT_WIN) && (state_q != WAIT_WIN);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_arstn) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            tick_q      <= '0;
            win_entry_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            result_q    <= '0;
            err_q       <= E_OK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            tick_q      <= tick_d;
            win_entry_q <= win_entry_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign err           = err_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_drm_freq_probe_master.sv
// Directed bench for drm_freq_probe_master with a small AXI4-Lite slave model
// (version register plus a saturating counter cleared by the write).
module tb_drm_freq_probe_master;

    localparam logic [15:0] BASE = 16'hFFF8;
    localparam logic [31:0] EXPV = 32'h60DC0DE0;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0;
    logic        window_tick = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [2:0]  err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    drm_freq_probe_master #(.WINDOW_TICKS(4), .TIMEOUT(16)) dut (
        .m_axi_aclk(clk), .m_axi_arstn(arstn), .start(start), .window_tick(window_tick),
        .busy(busy), .done(done), .result(result), .err(err),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    int total = 0;
    int bad   = 0;

    // slave knobs
    logic [31:0] ver_val = EXPV;
    bit          ar_block = 0;
    bit          cnt_err = 0;
    bit          cnt_stuck = 0;
    int          w_skew = 0;

    // slave state and observations
    logic [31:0] cnt_reg = '0;
    logic [15:0] rd_addr = '0, aw_addr = '0;
    logic [15:0] raddr_log [0:1];
    bit          rd_pend = 0, r_hs = 0, b_hs = 0, b_pend = 0, aw_got = 0, w_got = 0, w_prev_pend = 0;
    int          wcnt = 0, tick_ph = 0, cyc = 0;
    int          n_reads = 0, n_aw = 0, n_w = 0, n_b = 0, n_done = 0, ar_hi = 0, w_viol = 0;
    int          r_hs_cyc = 0, done_cyc = 0;

    // Slave model and monitors, evaluated at the falling edge where DUT outputs are stable.
    always @(negedge clk) begin
        cyc++;
        if (!arstn) begin
            arready = 0; rvalid = 0; rdata = '0; rresp = '0;
            awready = 0; wready = 0; bvalid = 0; bresp = '0; window_tick = 0;
            rd_pend = 0; r_hs = 0; b_hs = 0; b_pend = 0; aw_got = 0; w_got = 0;
            w_prev_pend = 0; wcnt = 0;
        end else begin
            if (cnt_stuck) cnt_reg = 32'hFFFF_FFFF;
            else if (cnt_reg != 32'hFFFF_FFFF) cnt_reg = cnt_reg + 32'd1;
            tick_ph++;
            window_tick = (tick_ph != 0) && (tick_ph % 10 == 0);
            if (r_hs) begin rvalid = 0; rresp = '0; r_hs = 0; end
            if (b_hs) begin bvalid = 0; b_hs = 0; end
            if (rd_pend) begin
                rvalid = 1; rd_pend = 0;
                if (rd_addr == BASE) begin rdata = ver_val; rresp = 2'b00; end
                else begin rdata = cnt_reg; rresp = cnt_err ? 2'b10 : 2'b00; end
            end
            if (b_pend) begin bvalid = 1; bresp = 2'b00; b_pend = 0; end
            if (aw_got && wcnt != 0) wcnt--;
            arready = arvalid && !ar_block && !rvalid;
            awready = awvalid && !aw_got;
            wready  = wvalid && ((w_skew == 0) || (aw_got && wcnt == 0));
            if (wvalid && (wdata != 32'd0 || wstrb != 4'hF)) w_viol++;
            if (w_prev_pend && !wvalid) w_viol++;
            if (arvalid && arready) begin
                rd_pend = 1; rd_addr = araddr;
                if (n_reads < 2) raddr_log[n_reads] = araddr;
                n_reads++;
            end
            if (rvalid && rready) begin r_hs = 1; r_hs_cyc = cyc; end
            if (awvalid && awready) begin aw_got = 1; wcnt = w_skew; n_aw++; aw_addr = awaddr; end
            if (wvalid && wready) begin
                w_got = 1; n_w++; tick_ph = 0;
                if (!cnt_stuck) cnt_reg = '0;
            end
            w_prev_pend = wvalid && !wready;
            if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
            if (bvalid && bready) begin b_hs = 1; n_b++; end
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (arvalid) ar_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_reads = 0; n_aw = 0; n_w = 0; n_b = 0; n_done = 0; ar_hi = 0; w_viol = 0;
        raddr_log[0] = '0; raddr_log[1] = '0;
    endtask

    // Pulse start for one cycle, then wait (bounded) for done.
    task automatic run(input string tag, output logic got);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_ctl"}, 32'({arvalid, rready, awvalid, wvalid, bready, busy, done}), 32'd0);
        chk({tag, "_addr"}, {araddr, awaddr}, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_wstrb_err"}, 32'({wstrb, err}), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
    endtask

    logic got;
    int   nd;

    initial begin
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_reset("reset");
        chk("reset_prot", 32'({awprot, arprot}), 32'd0);
        arstn = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, with the start-to-arvalid latency checked in the cycle after start.
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nom_arvalid_t1", 32'(arvalid), 32'd1);
        chk("nom_busy_t1", 32'(busy), 32'd1);
        chk("nom_araddr_t1", 32'(araddr), 32'(BASE));
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("nom_done_seen", 32'(got), 32'd1);
        chk("nom_err", 32'(err), 32'd0);
        chk("nom_result_in_40_48", 32'((result >= 32'd40) && (result <= 32'd48)), 32'd1);
        chk("nom_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("nom_done_one_cycle", 32'(done), 32'd0);
        @(negedge clk);
        chk("nom_reads", n_reads, 32'd2);
        chk("nom_writes", 32'({n_aw[7:0], n_w[7:0], n_b[7:0]}), 32'h010101);
        chk("nom_done_count", n_done, 32'd1);
        chk("nom_raddrs", {raddr_log[0], raddr_log[1]}, {BASE, BASE + 16'd4});
        chk("nom_awaddr", 32'(aw_addr), 32'(BASE + 16'd4));
        chk("nom_result_held", 32'((result >= 32'd40) && (result <= 32'd48)), 32'd1);

        // Version mismatch.
        clear_stats();
        ver_val = 32'h12345678;
        run("ver", got);
        chk("ver_err", 32'(err), 32'd1);
        chk("ver_result", result, 32'd0);
        repeat (2) @(negedge clk);
        chk("ver_no_write", 32'(n_aw + n_w), 32'd0);
        chk("ver_reads", n_reads, 32'd1);
        chk("ver_done_lat", 32'(done_cyc - r_hs_cyc), 32'd1);
        ver_val = EXPV;

        // AW/W skew: wready three cycles after awready.
        clear_stats();
        w_skew = 3;
        run("skew", got);
        chk("skew_err", 32'(err), 32'd0);
        chk("skew_result_in_40_48", 32'((result >= 32'd40) && (result <= 32'd48)), 32'd1);
        repeat (2) @(negedge clk);
        chk("skew_w_stable", w_viol, 32'd0);
        chk("skew_single_b", 32'({n_aw[7:0], n_w[7:0], n_b[7:0]}), 32'h010101);
        w_skew = 0;

        // Timeout: arready never asserted.
        clear_stats();
        ar_block = 1;
        run("tmo", got);
        chk("tmo_err", 32'(err), 32'd2);
        chk("tmo_arvalid_dropped", 32'(arvalid), 32'd0);
        repeat (2) @(negedge clk);
        chk("tmo_arvalid_cycles", ar_hi, 32'd16);
        chk("tmo_done_count", n_done, 32'd1);
        ar_block = 0;

        // SLVERR on the counter read.
        cnt_err = 1;
        run("rsp", got);
        chk("rsp_err", 32'(err), 32'd3);
        repeat (2) @(negedge clk);
        cnt_err = 0;

        // Counter saturated.
        cnt_stuck = 1;
        run("sat", got);
        chk("sat_err", 32'(err), 32'd4);
        chk("sat_result", result, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        cnt_stuck = 0;

        // Reset in the middle of WAIT_WIN, then a normal run.
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && n_b == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rst_in_window_busy", 32'(busy), 32'd1);
        arstn = 1'b0;
        @(negedge clk);
        chk_all_reset("rst_mid");
        nd = n_done;
        @(negedge clk);
        arstn = 1'b1;
        repeat (60) @(negedge clk);
        chk("rst_no_done", 32'(n_done - nd), 32'd0);
        chk("rst_idle", 32'({busy, arvalid}), 32'd0);
        run("restart", got);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_result_in_40_48", 32'((result >= 32'd40) && (result <= 32'd48)), 32'd1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drm_freq_probe_master.md
# drm_freq_probe_master

AXI4-Lite master that runs the DRM controller frequency-detection sequence against the controller's register window. It does three things in order. First, it checks the frequency-counter version word. Second, it clears the controller-side counter with a write. Third, after a window defined by an external timebase tick, it reads the counter back. The result is the number of controller bus clocks elapsed in the window. The block sits in the shell or test harness in front of the controller's AXI4-Lite slave port and is used for self-test and clock calibration.

## Interface
Parameters:
- BASE_ADDR, 16'hFFF8: byte address of the version word. Counter is at BASE_ADDR+4.
- EXP_VERSION, 32'h60DC0DE0: expected version word.
- WINDOW_TICKS, 1000: number of window_tick pulses in the measurement window. Range 1..65535.
- TIMEOUT, 1024: maximum cycles allowed per AXI phase before abort. Must be ≥ 2.

Ports:
- m_axi_aclk, in, 1: single clock for all logic.
- m_axi_arstn, in, 1: reset, synchronous, active-low.
- start, in, 1: single-cycle request. Ignored while busy.
- window_tick, in, 1: synchronous timebase pulse. Counted only in WAIT_WIN.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse when a run ends, on success or error.
- result, out, 32: counter value read back. Holds until the next accepted start.
- err, out, 3: run status, valid with done and held afterwards.
  - 0: ok
  - 1: version mismatch
  - 2: timeout
  - 3: SLVERR/DECERR response
  - 4: counter saturated (32'hFFFFFFFF)
- m_axi_awvalid/awready/awaddr[15:0]/awprot[2:0]: write address channel.
- m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]: write data channel.
- m_axi_bvalid/bready/bresp[1:0]: write response channel.
- m_axi_arvalid/arready/araddr[15:0]/arprot[2:0]: read address channel.
- m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]: read data channel.

## Operation
- States: IDLE → RD_VER_A → RD_VER_R → WR_CLR → WR_B → WAIT_WIN → RD_CNT_A → RD_CNT_R → DONE → IDLE.
- IDLE: on start, clear result and err, then go to RD_VER_A.
- RD_VER_A: araddr=BASE_ADDR, arvalid=1, held until arready.
- RD_VER_R: rready=1. On rvalid:
  - rresp≠0 → err=3, go to DONE.
  - rdata≠EXP_VERSION → err=1, go to DONE.
  - otherwise go to WR_CLR.
- WR_CLR: awaddr=BASE_ADDR+4, wdata=0, wstrb=4'hF, with awvalid and wvalid both asserted.
  - Each valid is held independently until its own ready.
  - The slave may return wready only after awready, so the master must not wait for both readies in the same cycle.
  - Leave the state once both handshakes are done.
- WR_B: bready=1. On bvalid:
  - bresp≠0 → err=3, go to DONE.
  - otherwise go to WAIT_WIN.
- WAIT_WIN: 16-bit tick counter, cleared on entry, increments on each window_tick. Go to RD_CNT_A in the cycle after the tick that makes the count equal WINDOW_TICKS.
- RD_CNT_A / RD_CNT_R: read BASE_ADDR+4, same rules as the version read. On rvalid:
  - latch result=rdata.
  - rresp≠0 → err=3.
  - else rdata=32'hFFFFFFFF → err=4.
  - else err=0.
- DONE: done=1 for one cycle, busy=0 from the same cycle, then return to IDLE.
- Timeout: a per-phase cycle counter runs in each AXI state (RD_VER_A, RD_VER_R, WR_CLR, WR_B, RD_CNT_A, RD_CNT_R).
  - Cleared on every state change.
  - On reaching TIMEOUT: drop all valids and readies, set err=2, go to DONE.
  - In RD_CNT_R, result keeps its cleared value.
- Only one outstanding transaction at a time. awprot and arprot are always 3'b000.

## Timing
- Reset values: all valids and readies 0, addresses/wdata/wstrb 0, busy 0, done 0, result 0, err 0, state IDLE.
- Reset mid-run: the next cycle all outputs are at their reset values and no done pulse is produced.
- Valid and ready outputs are registered. No combinational path exists from any input to any output.
- start accepted in cycle T → arvalid=1 and busy=1 at T+1.
- Final rvalid&rready in cycle T → done=1 at T+1, with result and err already valid at T+1.
- window_tick asserted in the same cycle that WAIT_WIN is entered is not counted.
- start asserted together with done is ignored.

## Test plan
- Nominal run: bench slave model with a version register and a saturating counter that clears on write. WINDOW_TICKS=4, tick every 10 cycles. Required: one done pulse, err=0, result in 40..48, exactly 2 reads and 1 write observed.
- Version mismatch: slave returns 32'h12345678. Required: err=1, no write issued, done 1 cycle after the R handshake.
- AW/W skew: slave asserts wready 3 cycles after awready. Required: wvalid held stable with wdata=0 until its handshake, then a single B accepted.
- Timeout: slave never asserts arready, TIMEOUT=16. Required: arvalid drops after 16 cycles, err=2, done pulses.
- Error response and saturation, in separate runs. Slave returns rresp=2'b10 on the counter read → err=3. Slave counter stuck at 32'hFFFFFFFF → err=4 and result=32'hFFFFFFFF.
- Reset and restart: deassert m_axi_arstn during WAIT_WIN. Required: all outputs at reset values next cycle, no done pulse. A subsequent start completes a run normally.
